// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - shared register map, CTRL fields, MODE and FSM encodings for timer_counter
package timer_counter_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_AUTO    = 2'd1,
        MODE_RSVD2   = 2'd2,
        MODE_RSVD3   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - word-addressed register bus and interrupt line of timer_counter
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - programmable down-counter timer with one-shot / auto-reload interrupt
// Optional macro TIMER_AUTORELOAD_EN enables MODE 1 (auto-reload with 1-cycle irq pulse).
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    logic        en;
    logic        im;
    mode_e       mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_next;
    logic        flag;
    logic        flag_next;
    logic        im_next;
    logic        irq_q;
    logic        hw_en_clr;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [1:0]  wr_mode;
    logic        auto_mode;
    state_e      state;
    state_e      state_next;

    assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
    assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);

`ifdef TIMER_AUTORELOAD_EN
    assign wr_mode   = bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign auto_mode = (mode == MODE_AUTO);
`else
    assign wr_mode   = 2'b00;
    assign auto_mode = 1'b0;
`endif

    always_comb begin
        state_next = state;
        count_next = count;
        hw_en_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) state_next = S_LOAD;
            end
            S_LOAD: begin
                count_next = preset;
                state_next = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_next = S_IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // 0 and 1 both expire here, so the counter never wraps
                    count_next = 32'd0;
                    state_next = S_INT;
                end
            end
            S_INT: begin
                if (auto_mode) begin
                    state_next = S_LOAD;
                end else begin
                    hw_en_clr  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // irq is computed from next-cycle flag/IM so it rises on the same edge INT is entered
    always_comb begin
        im_next   = ctrl_wr ? bus.wdata[CTRL_IM_BIT] : im;
        flag_next = flag;
        if (auto_mode) begin
            flag_next = (state_next == S_INT);
        end else if ((state_next == S_INT) && (state != S_INT)) begin
            flag_next = 1'b1;
        end else if (ctrl_wr) begin
            flag_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= 32'd0;
            preset <= 32'd0;
            en     <= 1'b0;
            im     <= 1'b0;
            mode   <= MODE_ONESHOT;
            flag   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            flag  <= flag_next;
            irq_q <= im_next & flag_next;
            if (ctrl_wr) begin
                en   <= bus.wdata[CTRL_EN_BIT];
                im   <= bus.wdata[CTRL_IM_BIT];
                mode <= mode_e'(wr_mode);
            end else if (hw_en_clr) begin
                en <= 1'b0;
            end
            if (preset_wr) preset <= bus.wdata;
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            ADDR_CTRL:   bus.rdata = {28'd0, im, mode, en};
            ADDR_PRESET: bus.rdata = preset;
            ADDR_COUNT:  bus.rdata = count;
            ADDR_RSVD:   bus.rdata = 32'd0;
            default:     bus.rdata = 32'd0;
        endcase
    end

    assign bus.irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed self-checking bench for timer_counter
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    logic [31:0] d;
    logic        irq_seen;
    logic [31:0] cnt_exp [10];
    logic        irq_exp [10];

    timer_counter_if bus ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        bus.addr  = a;
        bus.wdata = v;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.rdata;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 32'd0;
        cnt_exp = '{32'd0, 32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        irq_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rd(ADDR_CTRL, d);   check_eq("rst_ctrl", d, 32'h0);
        rd(ADDR_PRESET, d); check_eq("rst_preset", d, 32'h0);
        rd(ADDR_COUNT, d);  check_eq("rst_count", d, 32'h0);
        check_eq("rst_irq", {31'd0, bus.irq}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // one-shot, PRESET=5: irq rises 7 edges after the CTRL write edge and stays
        bus_write(ADDR_PRESET, 32'd5);
        bus_write(ADDR_CTRL, 32'h9);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rd(ADDR_COUNT, d);
            check_eq($sformatf("os5_count_k%0d", k), d, cnt_exp[k]);
            check_eq($sformatf("os5_irq_k%0d", k), {31'd0, bus.irq}, {31'd0, irq_exp[k]});
        end
        rd(ADDR_CTRL, d); check_eq("os5_ctrl_en_cleared", d, 32'h8);

        bus_write(ADDR_CTRL, 32'h8);
        @(negedge clk);
        check_eq("clr_irq_low", {31'd0, bus.irq}, 32'h0);
        repeat (4) @(negedge clk);
        check_eq("clr_irq_stays_low", {31'd0, bus.irq}, 32'h0);
        rd(ADDR_COUNT, d); check_eq("clr_count_idle", d, 32'h0);

        // MODE field: auto-reload when built with TIMER_AUTORELOAD_EN, forced to one-shot otherwise
        bus_write(ADDR_PRESET, 32'd3);
        bus_write(ADDR_CTRL, 32'hB);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
`ifdef TIMER_AUTORELOAD_EN
            if (k == 0) begin
                rd(ADDR_CTRL, d); check_eq("ar_ctrl_rb", d, 32'hB);
            end
            check_eq($sformatf("ar_irq_k%0d", k), {31'd0, bus.irq},
                     {31'd0, (k >= 5) && (((k - 5) % 5) == 0)});
`else
            if (k == 0) begin
                rd(ADDR_CTRL, d); check_eq("nm_ctrl_rb", d, 32'h9);
            end
            check_eq($sformatf("nm_irq_k%0d", k), {31'd0, bus.irq}, {31'd0, k >= 5});
`endif
        end
        rd(ADDR_CTRL, d);
`ifdef TIMER_AUTORELOAD_EN
        check_eq("ar_ctrl_en_kept", d, 32'hB);
`else
        check_eq("nm_ctrl_en_cleared", d, 32'h8);
`endif
        bus_write(ADDR_CTRL, 32'h0);
        repeat (8) @(negedge clk);
        check_eq("mode_stop_irq", {31'd0, bus.irq}, 32'h0);

        // IM=0: counter expires silently
        bus_write(ADDR_PRESET, 32'd100);
        bus_write(ADDR_CTRL, 32'h1);
        irq_seen = 1'b0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            irq_seen = irq_seen | bus.irq;
        end
        check_eq("im0_irq_never", {31'd0, irq_seen}, 32'h0);
        rd(ADDR_COUNT, d); check_eq("im0_count_expired", d, 32'h0);
        rd(ADDR_CTRL, d);  check_eq("im0_ctrl", d, 32'h0);

        // disable mid-count: count shown 41 before the write edge, 40 after, then held
        bus_write(ADDR_PRESET, 32'd60);
        bus_write(ADDR_CTRL, 32'h9);
        repeat (22) @(negedge clk);
        rd(ADDR_COUNT, d); check_eq("stop_count_before", d, 32'd41);
        bus_write(ADDR_CTRL, 32'h8);
        repeat (5) @(negedge clk);
        rd(ADDR_COUNT, d); check_eq("stop_count_held", d, 32'd40);
        rd(ADDR_CTRL, d);  check_eq("stop_ctrl", d, 32'h8);
        check_eq("stop_irq", {31'd0, bus.irq}, 32'h0);
        repeat (5) @(negedge clk);
        rd(ADDR_COUNT, d); check_eq("stop_count_still", d, 32'd40);

        // PRESET=1 timing and bus write beating the hardware EN clear
        bus_write(ADDR_PRESET, 32'd1);
        bus_write(ADDR_CTRL, 32'h9);
        repeat (3) @(negedge clk);
        check_eq("p1_irq_k2", {31'd0, bus.irq}, 32'h0);
        @(negedge clk);
        check_eq("p1_irq_k3", {31'd0, bus.irq}, 32'h1);
        bus_write(ADDR_CTRL, 32'h9);
        @(negedge clk);
        rd(ADDR_CTRL, d); check_eq("race_ctrl_wins", d, 32'h9);
        check_eq("race_irq_cleared", {31'd0, bus.irq}, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("race_irq_k2", {31'd0, bus.irq}, 32'h0);
        @(negedge clk);
        check_eq("race_irq_k3", {31'd0, bus.irq}, 32'h1);
        repeat (2) @(negedge clk);
        rd(ADDR_CTRL, d); check_eq("race_ctrl_final", d, 32'h8);
        check_eq("race_irq_sticky", {31'd0, bus.irq}, 32'h1);

        // reset mid-count, with a simultaneous PRESET write that must lose
        bus_write(ADDR_PRESET, 32'd60);
        bus_write(ADDR_CTRL, 32'h9);
        repeat (10) @(negedge clk);
        rd(ADDR_COUNT, d); check_eq("rst_mid_count_before", d, 32'd53);
        reset     = 1'b1;
        bus.addr  = ADDR_PRESET;
        bus.wdata = 32'h1234;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        bus.we = 1'b0;
        @(negedge clk);
        rd(ADDR_CTRL, d);   check_eq("rst_mid_ctrl", d, 32'h0);
        rd(ADDR_PRESET, d); check_eq("rst_mid_preset", d, 32'h0);
        rd(ADDR_COUNT, d);  check_eq("rst_mid_count", d, 32'h0);
        check_eq("rst_mid_irq", {31'd0, bus.irq}, 32'h0);
        bus_write(ADDR_COUNT, 32'hFFFF);
        bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
        @(negedge clk);
        rd(ADDR_COUNT, d);  check_eq("count_ro", d, 32'h0);
        rd(ADDR_RSVD, d);   check_eq("rsvd_reads0", d, 32'h0);
        rd(ADDR_CTRL, d);   check_eq("rsvd_no_ctrl", d, 32'h0);
        rd(ADDR_PRESET, d); check_eq("rsvd_no_preset", d, 32'h0);
        irq_seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            irq_seen = irq_seen | bus.irq;
        end
        check_eq("rst_mid_no_irq", {31'd0, irq_seen}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
